ramfifo_fwft_reader: RTL and testbench

Read-side stage downstream of the counter-based RAM FIFO controller and its synchronous-read RAM. It issues read strobes to the controller, captures the RAM words that return one cycle later and presents them as a first-word-fall-through valid/ready stream. A 3-entry output buffer with credit accounting sustains one word per clock. No combinational path exists from `out_ready` to `fifo_read`.

---
 rtl/ramfifo_fwft_reader.sv | 73 +++++++
 tb/tb_ramfifo_fwft_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ramfifo_fwft_reader.sv
// First-word-fall-through read stage for a counter-based RAM FIFO with a synchronous-read RAM.
// Define RAMFIFO_FWFT_FLUSH_EN to add the synchronous flush input.
module ramfifo_fwft_reader #(
  parameter int WIDTH = 36
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef RAMFIFO_FWFT_FLUSH_EN
  input  logic             flush,
`endif
  output logic [1:0]       level
);

  logic [WIDTH-1:0] r_mem [3];
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_level;
  logic             r_inflight;

  logic             w_flush;
  logic             w_pop;
  logic             w_capture;
  logic             w_credit;
  logic [2:0]       w_committed;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef RAMFIFO_FWFT_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Credit check uses registered state only, so out_ready never reaches fifo_read.
  assign w_committed = {1'b0, r_level} + {2'b00, r_inflight};
  assign w_credit    = (w_committed < 3'd3);
  assign fifo_read   = reset_n & enable & ~fifo_empty & ~w_flush & w_credit;

  assign w_capture = r_inflight & ~w_flush;
  assign out_valid = (r_level != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign level     = r_level;

  always_ff @(posedge clock) begin
    if (!reset_n || w_flush) begin
      r_inflight <= 1'b0;
      r_level    <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_wr_ptr   <= 2'd0;
    end else begin
      r_inflight <= fifo_read;
      r_level    <= r_level + {1'b0, r_inflight} - {1'b0, w_pop};
      if (w_capture) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)     r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // Storage is data only; out_data is masked while nothing is buffered.
  always_ff @(posedge clock) begin
    if (w_capture) r_mem[r_wr_ptr] <= ram_rdata;
  end

endmodule

// File: tb/tb_ramfifo_fwft_reader.sv
// Bench for ramfifo_fwft_reader: FIFO/RAM model plus an ordered-word reference model.
module tb_ramfifo_fwft_reader;
  localparam int WIDTH = 36;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             fifo_empty;
  logic             fifo_read;
  logic [WIDTH-1:0] ram_rdata;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;
  logic [1:0]       level;

  always #5 clock = ~clock;

  ramfifo_fwft_reader #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .ram_rdata  (ram_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
`ifdef RAMFIFO_FWFT_FLUSH_EN
    .flush      (flush),
`endif
    .level      (level)
  );

  typedef struct {
    logic             rst_n;
    logic             en;
    logic             rdy;
    logic             e_fr;
    logic             e_vld;
    logic [1:0]       e_lvl;
    logic [WIDTH-1:0] e_data;
  } vec_t;

  vec_t             tbl [13];
  logic [WIDTH-1:0] fq [$];     // words waiting in the FIFO controller
  logic [WIDTH-1:0] exp_q [$];  // words read from the FIFO and not yet consumed, oldest first
  bit               infl;
  int               total = 0;
  int               bad = 0;
  int               n_rd = 0;
  int               n_pop = 0;
  bit               chk_on = 0;
  bit               tbl_on = 0;
  int               tbl_row = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic cycle();
    logic fr_s, pop_s, rst_s, fl_s, exp_fr;
    int   lvl;
    @(negedge clock);
    fr_s  = fifo_read;
    pop_s = out_valid & out_ready;
    rst_s = reset_n;
    fl_s  = flush;
    if (chk_on) begin
      lvl    = exp_q.size() - int'(infl);
      exp_fr = rst_s & enable & (fq.size() != 0) & ~fl_s & (exp_q.size() < 3);
      chk("fifo_read", fr_s, exp_fr);
      chk("level", level, lvl);
      chk("out_valid", out_valid, lvl != 0);
      if (lvl != 0) chk("out_data", out_data, exp_q[0]);
      else          chk("out_data_idle", out_data, 0);
      chk("credit_bound", level + infl <= 3, 1);
    end
    if (tbl_on) begin
      chk("tbl_fifo_read", fr_s, tbl[tbl_row].e_fr);
      chk("tbl_out_valid", out_valid, tbl[tbl_row].e_vld);
      chk("tbl_level", level, tbl[tbl_row].e_lvl);
      chk("tbl_out_data", out_data, tbl[tbl_row].e_data);
    end
    @(posedge clock);
    #1;
    if (fr_s === 1'b1) n_rd++;
    if (pop_s === 1'b1) n_pop++;
    if (!rst_s || fl_s) begin
      exp_q.delete();
      infl = 0;
    end else begin
      if (pop_s === 1'b1 && exp_q.size() != 0) void'(exp_q.pop_front());
      if (fr_s === 1'b1 && fq.size() != 0) begin
        ram_rdata = fq.pop_front();
        exp_q.push_back(ram_rdata);
      end
      infl = (fr_s === 1'b1);
    end
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    int rd0, pop0;
    logic [WIDTH-1:0] w;
    reset_n = 1'b0; enable = 1'b1; out_ready = 1'b1; flush = 1'b0;
    fifo_empty = 1'b1; ram_rdata = '0; infl = 0;
    for (int i = 0; i < 13; i++) begin
      tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, WIDTH'(i - 3)};
      if (i < 2)        tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, '0};
      else if (i < 4)   tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, '0};
      else if (i >= 12) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, '0};
      else if (i >= 10) tbl[i].e_fr = 1'b0;
    end
    cycle(); cycle();
    chk_on = 1;

    // Reset with a non-empty FIFO, then 8 preloaded words streamed back to back.
    for (int i = 1; i <= 8; i++) push_word(WIDTH'(i));
    tbl_on = 1;
    for (int i = 0; i < 13; i++) begin
      reset_n = tbl[i].rst_n; enable = tbl[i].en; out_ready = tbl[i].rdy;
      tbl_row = i;
      cycle();
    end
    tbl_on = 0;

    // Backpressure: 5 words, consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(WIDTH'(36'h100 + i));
    rd0 = n_rd;
    for (int i = 0; i < 8; i++) cycle();
    chk("bp_reads", n_rd - rd0, 3);
    chk("bp_level", level, 3);
    chk("bp_head", out_data, 36'h100);
    out_ready = 1'b1;
    pop0 = n_pop;
    for (int i = 0; i < 5; i++) cycle();
    chk("bp_drain_pops", n_pop - pop0, 5);
    chk("bp_drained", out_valid, 0);

    // Single word with toggling ready.
    rd0 = n_rd; pop0 = n_pop;
    push_word(36'hABC);
    for (int i = 0; i < 10; i++) begin
      out_ready = i[0];
      cycle();
    end
    chk("single_reads", n_rd - rd0, 1);
    chk("single_pops", n_pop - pop0, 1);

    // Enable dropped right after a read.
    enable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(WIDTH'(36'h200 + i));
    rd0 = n_rd; pop0 = n_pop;
    enable = 1'b1;
    cycle();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("en_off_reads", n_rd - rd0, 1);
    chk("en_off_pops", n_pop - pop0, 1);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    chk("en_on_pops", n_pop - pop0, 3);

`ifdef RAMFIFO_FWFT_FLUSH_EN
    // Flush with two buffered words and one in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(WIDTH'(36'h300 + i));
    for (int i = 0; i < 3; i++) cycle();
    chk("pre_flush_level", level, 2);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_level", level, 0);
    out_ready = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
        if (out_valid) begin
          seen = 1;
          chk("flush_next_head", out_data, 36'h303);
        end else cycle();
      end
      if (!seen) chk("flush_next_timeout", 0, 1);
    end
    for (int i = 0; i < 8; i++) cycle();
`endif

    // Randomized traffic including occasional mid-operation reset.
    for (int i = 0; i < 3000; i++) begin
      reset_n   = 1'b1;
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = 1'b0;
`ifdef RAMFIFO_FWFT_FLUSH_EN
      flush     = ($urandom_range(0, 99) == 0);
`endif
      if (fq.size() < 8 && $urandom_range(0, 1) == 1) begin
        w = {WIDTH'($urandom_range(0, 15)) << 32} | WIDTH'($urandom);
        push_word(w);
      end
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
